// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, depth and pointer type for ram_fifo and its storage.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;
    // MSB is the wrap bit; low DEF_ADDR_W bits address the RAM.
    typedef logic [DEF_ADDR_W:0] ptr_t;
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: 2**ADDR_W x DATA_W RAM, one write port and one registered read port.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write side; i_rd_en/i_rd_addr read request;
//        o_rd_data read data, valid the cycle after i_rd_en, holds otherwise.
// A read and write to the same address in one cycle return the old contents.
module dual_port_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/ram_fifo.sv
// ram_fifo: synchronous FIFO driving a dual_port_ram, with occupancy and sticky error flags.
// Ports: clk, rst (sync, active high); i_push/i_din producer side; i_pop consumer request;
//        o_dout/o_dout_valid read data one cycle after an accepted pop;
//        o_full, o_empty, o_count occupancy (registered pointers only);
//        o_overflow/o_underflow sticky rejected-push/rejected-pop flags.
module ram_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);
    ptr_t r_wr_ptr, r_rd_ptr;
    logic r_dout_valid, r_overflow, r_underflow;
    logic w_full, w_empty, w_pop_ok, w_push_ok;

    assign w_empty   = r_wr_ptr == r_rd_ptr;
    assign w_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                       (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_pop_ok  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_dout_valid <= w_pop_ok;
            if (i_push && !w_push_ok) r_overflow <= 1'b1;
            if (i_pop && !w_pop_ok) r_underflow <= 1'b1;
        end
    end

    // Writes are blocked during reset so a coincident push leaves no trace.
    dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push_ok & ~rst),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (i_din),
        .i_rd_en   (w_pop_ok),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (o_dout)
    );

    assign o_dout_valid = r_dout_valid;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_count      = r_wr_ptr - r_rd_ptr;
    assign o_overflow   = r_overflow;
    assign o_underflow  = r_underflow;
endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: directed scoreboard bench for ram_fifo against a queue reference model.
module tb_ram_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [7:0] din = '0;
    logic       pop = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, full, empty, overflow, underflow;
    logic [4:0] count;

    ram_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .i_push       (push),
        .i_din        (din),
        .i_pop        (pop),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_full       (full),
        .o_empty      (empty),
        .o_count      (count),
        .o_overflow   (overflow),
        .o_underflow  (underflow)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic       m_ovf, m_udf, m_valid;
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'(1), 32'(0));
            else chk({tag, ".dout"}, 32'(dout), 32'(sb.pop_front()));
        end
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic step(input string tag, input logic p, input logic [7:0] d, input logic q);
        logic pop_ok, push_ok;
        push = p; din = d; pop = q;
        pop_ok  = q && mq.size() > 0;
        push_ok = p && (mq.size() < DEPTH || pop_ok);
        if (pop_ok) sb.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok) m_udf = 1'b1;
        m_valid = pop_ok;
        @(posedge clk);
        #1;
        check_state(tag);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset(input string tag, input logic p, input logic q);
        rst = 1'b1; push = p; pop = q; din = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        mq.delete(); sb.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
        check_state(tag);
    endtask

    initial begin
        do_reset("rst0", 1'b0, 1'b0);

        step("b_push", 1, 8'h11, 0);
        step("b_push", 1, 8'h22, 0);
        step("b_push", 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) step("b_pop", 0, 8'h00, 1);
        step("b_idle", 0, 8'h00, 0);

        do_reset("rst1", 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("f_push", 1, 8'(i), 0);
        step("f_ovf", 1, 8'hAA, 0);
        for (int i = 0; i < 16; i++) step("f_pop", 0, 8'h00, 1);
        step("f_idle", 0, 8'h00, 0);

        do_reset("rst2", 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("s_push", 1, 8'(i), 0);
        step("s_both_full", 1, 8'h5A, 1);
        for (int i = 0; i < 16; i++) step("s_pop", 0, 8'h00, 1);
        step("s_idle", 0, 8'h00, 0);

        do_reset("rst3", 1'b0, 1'b0);
        step("u_pop_empty", 0, 8'h00, 1);
        step("u_both_empty", 1, 8'h77, 1);
        step("u_pop", 0, 8'h00, 1);
        step("u_idle", 0, 8'h00, 0);

        do_reset("rst4", 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("w_push", 1, 8'(i), 0);
            step("w_pop", 0, 8'h00, 1);
        end
        step("w_idle", 0, 8'h00, 0);

        do_reset("rst5", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("r_push", 1, 8'(8'hC0 + i), 0);
        step("r_pop", 0, 8'h00, 1);
        do_reset("r_rst_pop", 1'b1, 1'b1);
        step("r_idle", 0, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
